// File: rtl/pad_serial_receiver.sv
// NES/SNES-style serial pad poller: shared latch/clock, one data line per player.
// Define PAD_DETECT_EN to treat an all-zero read (pull-down only) as an unplugged pad.
module pad_serial_receiver #(
  parameter int BUTTONS = 8,
  parameter int PLAYERS = 1,
  parameter int CLK_DIV = 150
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [PLAYERS-1:0]         pad_data,
  output logic                       pad_latch,
  output logic                       pad_clk,
  output logic [PLAYERS*BUTTONS-1:0] buttons,
  output logic [PLAYERS*BUTTONS-1:0] pressed,
  output logic                       valid,
  output logic                       busy,
  output logic [PLAYERS-1:0]         connected
);

  // state    | meaning
  // IDLE     | latch low, clock high, waiting for start
  // LATCH    | latch high for 2*CLK_DIV cycles
  // CLK_LOW  | clock low, data sampled on the tick
  // CLK_HIGH | clock high, bit index advances on the tick
  // DONE     | publish buttons/pressed, pulse valid

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int IDX_W = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;
  localparam logic [DIV_W-1:0] TICK      = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_END = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BUTTONS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt, div_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             sample_en;
  logic             update_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      idx     <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    div_next   = div_cnt + 1'b1;
    idx_next   = idx;
    sample_en  = 1'b0;
    update_en  = 1'b0;
    case (state)
      IDLE: begin
        div_next = '0;
        if (start) state_next = LATCH;
      end
      LATCH: begin
        if (div_cnt == LATCH_END) begin
          state_next = CLK_LOW;
          idx_next   = '0;
        end
      end
      CLK_LOW: begin
        if (div_cnt == TICK) begin
          sample_en  = 1'b1;
          state_next = CLK_HIGH;
        end
      end
      CLK_HIGH: begin
        if (div_cnt == TICK) begin
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = CLK_LOW;
          end
        end
      end
      DONE: begin
        update_en  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // divider restarts on every state entry
    if (state_next != state) div_next = '0;
  end

  // pad pins come straight from flops so they never glitch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      pad_latch <= (state_next == LATCH);
      pad_clk   <= (state_next != CLK_LOW);
      busy      <= (state_next != IDLE);
      valid     <= update_en;
    end
  end

  for (genvar g = 0; g < PLAYERS; g++) begin : g_player
    logic [BUTTONS-1:0] shift_q;
    logic [BUTTONS-1:0] btn_q;
    logic [BUTTONS-1:0] prs_q;
    logic [BUTTONS-1:0] btn_new;
    logic               present;
    logic               conn_q;

    always_ff @(posedge clk) begin
      if (!rst_n) shift_q <= '0;
      else if (sample_en) shift_q[idx] <= pad_data[g];
    end

`ifdef PAD_DETECT_EN
    assign present = |shift_q;
`else
    assign present = 1'b1;
`endif

    assign btn_new = present ? ~shift_q : '0;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        btn_q  <= '0;
        prs_q  <= '0;
        conn_q <= 1'b1;
      end else if (update_en) begin
        btn_q  <= btn_new;
        prs_q  <= btn_new & ~btn_q;
        conn_q <= present;
      end
    end

    assign buttons[g*BUTTONS +: BUTTONS] = btn_q;
    assign pressed[g*BUTTONS +: BUTTONS] = prs_q;
    assign connected[g]                  = conn_q;
  end

endmodule

// File: doc/pad_serial_receiver.md
# pad_serial_receiver

Parametrised serial gamepad receiver driving the NES/SNES-style latch/clock/data protocol on the `uio` pins. It replaces the tied-off `NES_Latch`/`NES_Clk` outputs of the game top-level. It reads up to `PLAYERS` controllers in parallel, each `BUTTONS` bits long, and delivers active-high button and new-press vectors once per frame to the input controller and game-state logic.

## Interface

Parameters:

- `BUTTONS`, 8: bits shifted per controller; 8 = NES, 16 = SNES.
- `PLAYERS`, 1: number of controllers. They share latch and clock and have separate data lines.
- `CLK_DIV`, 150: half-period of `pad_clk` in `clk` cycles, ≥ 2. 150 at 25 MHz gives 6 µs.

Ports (clock and reset first):

- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset. Synchronous, active-low.
- `start`, input, 1: poll request, normally `frame_end`. Sampled only in IDLE.
- `pad_data`, input, `PLAYERS`: serial data, one bit per controller. Active-low; a pull-down is fitted externally.
- `pad_latch`, output, 1: controller latch.
- `pad_clk`, output, 1: controller shift clock. Idles high.
- `buttons`, output, `PLAYERS*BUTTONS`: held state. Active-high, registered. Bit `p*BUTTONS+k` is bit k of player p.
- `pressed`, output, `PLAYERS*BUTTONS`: buttons newly pressed in the latest poll, i.e. `new & ~old`.
- `valid`, output, 1: one-cycle pulse on every update of `buttons`/`pressed`.
- `busy`, output, 1: high from the accepted `start` until the `valid` edge.
- `connected`, output, `PLAYERS`: per-player presence flag (see Configuration).

## Operation

- FSM states are IDLE, LATCH, CLK_LOW, CLK_HIGH and DONE.
- A divider counter counts 0..`CLK_DIV`-1. It is cleared on every state entry. A "tick" is the cycle where the counter equals `CLK_DIV`-1.
- **IDLE.** `pad_latch`=0 and `pad_clk`=1. On `start`=1, go to LATCH and set `busy`=1.
- **LATCH.** `pad_latch`=1 for 2·`CLK_DIV` cycles, then go to CLK_LOW with bit index 0.
- **CLK_LOW.** `pad_clk`=0 for `CLK_DIV` cycles. On the tick cycle, `pad_data[p]` is shifted into shift register p at position index. Then go to CLK_HIGH.
- **CLK_HIGH.** `pad_clk`=1 for `CLK_DIV` cycles. On the tick:
  - if index = `BUTTONS`-1, go to DONE;
  - otherwise increment index and go to CLK_LOW.
- **DONE** (one cycle). The update is:
  - `buttons` ← ~shift;
  - `pressed` ← ~shift & ~`buttons`(old);
  - `valid`=1 and `busy`=0.
  - Then go to IDLE.
- Bit order: the first bit shifted is bit 0. For NES the order is A, B, Select, Start, Up, Down, Left, Right.
- `start` outside IDLE is ignored; it is not queued.
- `buttons` and `pressed` hold their values between updates. `pressed` is not cleared after `valid`.
- Inputs `pad_data` are used without synchronisers. The shift clock is slow relative to `clk`, and sampling occurs `CLK_DIV` cycles after the falling edge of `pad_clk`.

## Timing

- Reset values: `pad_latch`=0, `pad_clk`=1, `buttons`=0, `pressed`=0, `valid`=0, `busy`=0, `connected`=all ones, FSM=IDLE, index=0, divider=0.
- Reset asserted mid-poll aborts immediately at the next edge. The partial shift is discarded and `buttons` is cleared.
- `pad_latch` rises on the edge that samples `start`.
- `valid` is asserted (2+2·`BUTTONS`)·`CLK_DIV`+1 edges after that edge.
- `start` asserted in the same cycle as `valid` is ignored, because the FSM is still in DONE. The earliest accepted `start` is the cycle after `valid`.
- `pad_clk` produces exactly `BUTTONS` low pulses per poll, each `CLK_DIV` cycles long.

## Configuration

- The `PAD_DETECT_EN` macro controls presence detection.
- Defined: detection is active.
  - In DONE, a player whose raw shift register is all zeros is treated as unplugged. An unplugged controller reads all-pressed through the pull-down.
  - For such a player, `connected[p]`=0 and the player's `buttons` and `pressed` slices are forced to 0.
  - The flag recovers on the first poll that contains any 1.
- Undefined: `connected` is constantly all ones, and raw data is always used.

## Test plan

Default bench settings: `BUTTONS`=8, `PLAYERS`=2, `CLK_DIV`=4.

- **Reset.** Hold `rst_n`=0 for 3 cycles. Required: `pad_clk`=1, `pad_latch`=0, `buttons`=16'h0000, `busy`=0.
- **Single poll.** Pulse `start` with player0 driving serial 0,1,1,1,1,1,1,0 and player1 driving all 1s. Required:
  - `pad_latch` high for 8 cycles;
  - 8 `pad_clk` low pulses of 4 cycles each;
  - `valid` 73 edges after the start edge;
  - `buttons`=16'h0081 (A and Right) and `pressed`=16'h0081.
- **Repeat poll.** Repeat the poll with identical data. Required: `buttons`=16'h0081 and `pressed`=16'h0000.
- **Busy rejection.** Pulse `start` at cycle 20 of a poll. Required: no second latch pulse, and exactly one `valid`.
- **Mid-poll reset.** Assert `rst_n`=0 during CLK_LOW of bit 3. Required: the next cycle has `pad_clk`=1, `pad_latch`=0 and `buttons`=0, with no `valid`.
- **Presence detect.** With `PAD_DETECT_EN` defined, player1 drives all 0s. Required: `connected`=2'b01 and `buttons[15:8]`=0. Without the macro: `connected`=2'b11 and `buttons[15:8]`=8'hFF.
